pc_sequencer: RTL and testbench

- Control-side partner of the program counter: it decodes the instruction fetched at the current PC and drives the PC's jump_here, bnz and halt inputs.
- Holds a 16-entry branch-target lookup table (LUT) loaded by the host or bench.
- Runs a start/ack handshake: IDLE -> RUN -> DONE.
- Counts retired instructions and taken branches for performance checks.

---
 rtl/pc_sequencer.sv | 71 +++++++
 tb/tb_pc_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: decodes the instruction at the current PC, drives the PC's
// jump/branch/halt controls from a 16-entry branch-target LUT, counts activity.
module pc_sequencer #(
    parameter int addr_w = 16,
    parameter int instr_w = 9,
    parameter int lut_aw = 4,
    parameter int cnt_w = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [instr_w-1:0] instr,
    input  logic               zero_flag,
    input  logic               lut_we,
    input  logic [lut_aw-1:0]  lut_waddr,
    input  logic [addr_w-1:0]  lut_wdata,
    output logic [addr_w-1:0]  jump_here,
    output logic               bnz,
    output logic               halt,
    output logic               ack,
    output logic [cnt_w-1:0]   retired,
    output logic [cnt_w-1:0]   taken
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [addr_w-1:0] lut [2**lut_aw];
    logic [3:0] op;
    logic [addr_w-1:0] target;
    assign op = instr[instr_w-1 -: 4];
    assign target = lut[instr[lut_aw-1:0]];
    always_comb begin
        state_nx = state;
        jump_here = '0;
        bnz = 1'b0;
        halt = 1'b1;
        ack = 1'b0;
        case (state)
            IDLE: state_nx = start ? RUN : IDLE;
            RUN: begin
                jump_here = target;
                bnz = (op == 4'b1101) | ((op == 4'b1110) & ~zero_flag);
                halt = op == 4'b1111;
                state_nx = halt ? DONE : RUN;
            end
            DONE: begin
                ack = 1'b1;
                state_nx = start ? RUN : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            retired <= '0;
            taken <= '0;
            for (int i = 0; i < 2**lut_aw; i++) lut[i] <= '0;
        end else begin
            state <= state_nx;
            if (lut_we) lut[lut_waddr] <= lut_wdata;
            if (state != RUN && start) begin
                retired <= '0;
                taken <= '0;
            end else if (state == RUN) begin
                retired <= (retired == '1) ? retired : retired + cnt_w'(1);
                if (bnz) taken <= (taken == '1) ? taken : taken + cnt_w'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checking of pc_sequencer against a
// behavioural model; counter width is narrowed so saturation is reachable.
module tb_pc_sequencer;
    localparam int AW = 16, IW = 9, LA = 4, CW = 5;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [8:0] ALU = 9'h000, BNZ3 = 9'h1C3, JMP5 = 9'h1A5, JMP3 = 9'h1A3, HLT = 9'h1E0;

    logic clk = 0, reset = 1, start = 0, zero_flag = 0, lut_we = 0;
    logic [IW-1:0] instr = '0;
    logic [LA-1:0] lut_waddr = '0;
    logic [AW-1:0] lut_wdata = '0;
    logic [AW-1:0] jump_here;
    logic bnz, halt, ack;
    logic [CW-1:0] retired, taken;

    pc_sequencer #(.addr_w(AW), .instr_w(IW), .lut_aw(LA), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .zero_flag(zero_flag),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .jump_here(jump_here), .bnz(bnz), .halt(halt), .ack(ack),
        .retired(retired), .taken(taken)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = waiting, 1 = executing, 2 = finished.
    int m_lut[16];
    int m_mode = 0, m_ret = 0, m_tak = 0;
    bit m_valid = 0, stop = 0;

    function automatic bit m_branch();
        return m_mode == 1 && (instr[8:5] == 13 || (instr[8:5] == 14 && !zero_flag));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_ret = 0; m_tak = 0; m_valid = 1;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            if (m_mode != 1 && start) begin
                m_mode = 1; m_ret = 0; m_tak = 0;
            end else if (m_mode == 1) begin
                if (m_branch()) m_tak = (m_tak < MAXC) ? m_tak + 1 : MAXC;
                m_ret = (m_ret < MAXC) ? m_ret + 1 : MAXC;
                if (instr[8:5] == 15) m_mode = 2;
            end
            if (lut_we) m_lut[lut_waddr] = lut_wdata;
        end
    end

    always @(negedge clk) begin
        if (m_valid && !stop) begin
            chk("jump_here", jump_here, (m_mode == 1) ? m_lut[instr[3:0]] : 0);
            chk("bnz", bnz, m_branch());
            chk("halt", halt, m_mode != 1 || instr[8:5] == 15);
            chk("ack", ack, m_mode == 2);
            chk("retired", retired, m_ret);
            chk("taken", taken, m_tak);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 1;
        tick(); tick();
        reset = 0; start = 0;
        repeat (5) tick();
        chk("idle_halt", halt, 1); chk("idle_bnz", bnz, 0); chk("idle_ack", ack, 0);
        chk("idle_ret", retired, 0); chk("idle_tak", taken, 0); chk("idle_jh", jump_here, 0);
        lut_we = 1; lut_waddr = 3; lut_wdata = 16'h0040; tick();
        lut_waddr = 5; lut_wdata = 16'h0007; tick();
        lut_we = 0; start = 1; tick(); start = 0;
        instr = ALU; repeat (4) tick();
        instr = BNZ3; zero_flag = 0; #1;
        chk("bnz_taken", bnz, 1); chk("bnz_target", jump_here, 16'h0040);
        tick();
        chk("taken_1", taken, 1); chk("retired_5", retired, 5);
        zero_flag = 1; #1;
        chk("bnz_not_taken", bnz, 0);
        tick();
        chk("taken_hold", taken, 1); chk("retired_6", retired, 6);
        instr = JMP5; lut_we = 1; lut_waddr = 5; lut_wdata = 16'h0012; #1;
        chk("lut_old_read", jump_here, 16'h0007);
        tick(); lut_we = 0; #1;
        chk("lut_new_read", jump_here, 16'h0012);
        tick();
        instr = HLT; tick();
        start = 1; instr = ALU; tick(); start = 0;
        repeat (3) tick();
        instr = HLT; #1;
        chk("halt_decode", halt, 1);
        tick();
        instr = ALU; #1;
        chk("ack_done", ack, 1); chk("retired_4", retired, 4);
        start = 1; tick(); start = 0; #1;
        chk("restart_ack", ack, 0); chk("restart_ret", retired, 0);
        chk("restart_tak", taken, 0); chk("restart_halt", halt, 0);
        instr = JMP3; tick(); tick();
        chk("taken_2", taken, 2);
        reset = 1; tick(); reset = 0; #1;
        chk("abort_halt", halt, 1); chk("abort_tak", taken, 0); chk("abort_jh", jump_here, 0);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 16; i++) begin
            instr = {4'hD, 1'b0, 4'(i)}; #1;
            chk("lut_cleared", jump_here, 0);
            tick();
        end
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 15) == 0;
            r = $urandom_range(0, 39);
            instr[8:5] = (r == 0) ? 4'hF : (r < 5) ? 4'hD : (r < 12) ? 4'hE : 4'($urandom_range(0, 12));
            instr[4:0] = 5'($urandom);
            zero_flag = 1'($urandom);
            lut_we = $urandom_range(0, 3) == 0;
            lut_waddr = 4'($urandom);
            lut_wdata = 16'($urandom);
            tick();
        end
        stop = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
